// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the CPU/IOP memory bus arbiter.
// Holds the owner encoding, the default doorbell word addresses, the bus
// field types, and a helper that recognises a byte-0 doorbell write.
package mem_bus_arbiter_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_IOP = 1'b1
  } owner_t;

  typedef logic [15:31] addr_t;
  typedef logic [0:31]  data_t;
  typedef logic [0:3]   wen_t;

  localparam addr_t CPU_DOORBELL_DEF = 17'h20;
  localparam addr_t IOP_DOORBELL_DEF = 17'h21;

  // A doorbell rings only on a live cycle to the doorbell word with lane 0 set.
  function automatic logic is_doorbell(input logic req, input addr_t addr,
                                       input wen_t we, input addr_t bell);
    return req && (addr == bell) && we[0];
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// bus_watchdog: bounds how long the IOP may own the shared memory bus.
// Ports:
//   clock, reset     - system clock, synchronous active-high reset
//   active           - IOP owns the bus this cycle
//   enter            - bus is being handed to the IOP at the next edge
//   doorbell         - IOP is ringing its doorbell this cycle
//   expire           - combinational: reclaim the bus at the next edge
//   timeout          - registered one-cycle pulse after a reclaim
//   timeout_sticky   - set by a reclaim, cleared only by reset
module bus_watchdog #(
  parameter int unsigned IOP_TIMEOUT   = 4096,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic enter,
  input  logic doorbell,
  output logic expire,
  output logic timeout,
  output logic timeout_sticky
);

  // Counter value seen in the last permitted IOP cycle.
  localparam logic [TIMEOUT_WIDTH-1:0] LAST =
    (IOP_TIMEOUT == 0) ? '0 : TIMEOUT_WIDTH'(IOP_TIMEOUT - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] SAT = '1;

  logic [TIMEOUT_WIDTH-1:0] count;

  // A doorbell in the final cycle wins over expiry.
  assign expire = (IOP_TIMEOUT != 0) && active && (count == LAST) && !doorbell;

  always_ff @(posedge clock) begin
    if (reset) begin
      count          <= '0;
      timeout        <= 1'b0;
      timeout_sticky <= 1'b0;
    end else begin
      timeout <= expire;
      if (expire) timeout_sticky <= 1'b1;
      if (enter)
        count <= '0;
      else if (active && count != SAT)
        count <= count + TIMEOUT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: owns the single synchronous-read memory port shared by
// the CPU and the IOP. Ownership moves on byte-0 doorbell writes; a watchdog
// hands the bus back to the CPU if the IOP keeps it too long.
// Ports:
//   clock, reset                         - clock, synchronous active-high reset
//   cpu_req/address/write_en/data        - CPU memory cycle
//   iop_req/address/write_en/data        - IOP memory cycle
//   mem_address/write_en/data_in         - muxed memory request
//   cpu_active                           - CPU owns the bus (IOP enable = ~cpu_active)
//   cpu_rd_valid / iop_rd_valid          - memory data_out belongs to that side
//   timeout / timeout_sticky             - watchdog reclaim pulse / latched flag
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter addr_t       CPU_DOORBELL  = CPU_DOORBELL_DEF,
  parameter addr_t       IOP_DOORBELL  = IOP_DOORBELL_DEF,
  parameter int unsigned IOP_TIMEOUT   = 4096,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic [15:31] cpu_address,
  input  logic [0:3]   cpu_write_en,
  input  logic [0:31]  cpu_data,
  input  logic         iop_req,
  input  logic [15:31] iop_address,
  input  logic [0:3]   iop_write_en,
  input  logic [0:31]  iop_data,
  output logic [15:31] mem_address,
  output logic [0:3]   mem_write_en,
  output logic [0:31]  mem_data_in,
  output logic         cpu_active,
  output logic         cpu_rd_valid,
  output logic         iop_rd_valid,
  output logic         timeout,
  output logic         timeout_sticky
);

  owner_t owner;
  logic   cpu_ring, iop_ring, wd_expire;

  // Only the current owner can ring; the other side is ignored entirely.
  assign cpu_ring = (owner == OWN_CPU) &&
                    is_doorbell(cpu_req, cpu_address, cpu_write_en, CPU_DOORBELL);
  assign iop_ring = (owner == OWN_IOP) &&
                    is_doorbell(iop_req, iop_address, iop_write_en, IOP_DOORBELL);

  // Idle owner still steers address/data; only write enables are gated.
  always_comb begin
    if (owner == OWN_CPU) begin
      mem_address  = cpu_address;
      mem_data_in  = cpu_data;
      mem_write_en = cpu_req ? cpu_write_en : '0;
    end else begin
      mem_address  = iop_address;
      mem_data_in  = iop_data;
      mem_write_en = iop_req ? iop_write_en : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner        <= OWN_CPU;
      cpu_active   <= 1'b1;
      cpu_rd_valid <= 1'b0;
      iop_rd_valid <= 1'b0;
    end else begin
      // Tag by the owner at issue time so a cycle issued just before a
      // handoff still returns to its issuer.
      cpu_rd_valid <= (owner == OWN_CPU) && cpu_req;
      iop_rd_valid <= (owner == OWN_IOP) && iop_req;
      case (owner)
        OWN_CPU: if (cpu_ring) begin
          owner      <= OWN_IOP;
          cpu_active <= 1'b0;
        end
        OWN_IOP: if (iop_ring || wd_expire) begin
          owner      <= OWN_CPU;
          cpu_active <= 1'b1;
        end
        default: begin
          owner      <= OWN_CPU;
          cpu_active <= 1'b1;
        end
      endcase
    end
  end

  bus_watchdog #(
    .IOP_TIMEOUT  (IOP_TIMEOUT),
    .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
  ) u_watchdog (
    .clock         (clock),
    .reset         (reset),
    .active        (owner == OWN_IOP),
    .enter         (cpu_ring),
    .doorbell      (iop_ring),
    .expire        (wd_expire),
    .timeout       (timeout),
    .timeout_sticky(timeout_sticky)
  );

endmodule
